// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: owns the PC, issues one word request at a time and
// buffers returned instructions with their PCs in a DEPTH-entry circular queue.
module fetch_prefetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush_sig,
  input  logic [31:0] i_flush_pc,
  input  logic        i_branch_sig,
  input  logic [31:0] i_branch_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_decode_ready
);

  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   req_pc;
  logic          pending;
  logic          drop;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          redirect;
  logic [31:0]   target;
  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Flush outranks a branch; targets are always forced to word alignment.
  always_comb begin
    redirect = i_flush_sig | i_branch_sig;
    target   = (i_flush_sig ? i_flush_pc : i_branch_pc) & 32'hFFFF_FFFC;
  end

  // A request is only offered when no response is outstanding and a queue slot
  // is guaranteed, so the queue can never overflow.
  assign o_mem_req  = i_rst_n & ~redirect & ~pending & (count < FULL);
  assign o_mem_addr = pc_q;

  assign grant = o_mem_req & i_mem_gnt;
  assign resp  = i_mem_rvalid & pending;
  assign push  = resp & ~drop & ~redirect;
  assign pop   = o_inst_valid & i_decode_ready & ~redirect;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_PC;
      req_pc  <= '0;
      pending <= 1'b0;
      drop    <= 1'b0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else if (redirect) begin
      pc_q   <= target;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      // An in-flight response that has not arrived yet must be swallowed later.
      if (resp) begin
        pending <= 1'b0;
        drop    <= 1'b0;
      end else if (pending) begin
        drop <= 1'b1;
      end
    end else begin
      if (grant) begin
        pending <= 1'b1;
        req_pc  <= pc_q;
        pc_q    <= pc_q + 32'd4;
      end
      if (resp) begin
        pending <= 1'b0;
        drop    <= 1'b0;
      end
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= i_mem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

  assign o_inst_valid = (count != '0);
  assign o_inst       = o_inst_valid ? inst_mem[rd_ptr] : NOP;
  assign o_pc         = o_inst_valid ? pc_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the fetch stage.
module tb_fetch_prefetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_sig = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch_sig = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        decode_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model state: fetch PC, one outstanding request, and the queue of {pc, inst}.
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  bit          m_pending;
  bit          m_drop;
  logic [63:0] m_q[$];

  logic [31:0] gnt_log[$];
  logic [31:0] seen_pc[$];
  logic [31:0] seen_inst[$];

  fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_flush_sig(flush_sig), .i_flush_pc(flush_pc),
    .i_branch_sig(branch_sig), .i_branch_pc(branch_pc),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_inst_valid(inst_valid), .o_inst(inst), .o_pc(pc),
    .i_decode_ready(decode_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit          exp_req;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    exp_req  = !(flush_sig || branch_sig) && !m_pending && (m_q.size() < DEPTH);
    exp_inst = (m_q.size() != 0) ? m_q[0][31:0]  : NOP;
    exp_pc   = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    check("mem_req",    32'(mem_req),    32'(exp_req));
    check("mem_addr",   mem_addr,        m_pc);
    check("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    check("inst",       inst,            exp_inst);
    check("pc",         pc,              exp_pc);
    if (mem_req && mem_gnt) gnt_log.push_back(mem_addr);
    if (inst_valid && decode_ready && !(flush_sig || branch_sig)) begin
      seen_pc.push_back(pc);
      seen_inst.push_back(inst);
    end
  endtask

  // Drive one cycle from a negedge, check outputs, then advance the model.
  task automatic applyStimulus(input bit fl, input logic [31:0] fpc, input bit br,
                               input logic [31:0] bpc, input bit gnt, input bit rv,
                               input logic [31:0] rd, input bit rdy);
    bit req;
    bit do_pop;
    flush_sig = fl; flush_pc = fpc; branch_sig = br; branch_pc = bpc;
    mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rd; decode_ready = rdy;
    #1;
    checkOutput();
    @(posedge clk);
    if (fl || br) begin
      if (rv && m_pending) begin
        m_pending = 0;
        m_drop    = 0;
      end else if (m_pending) begin
        m_drop = 1;
      end
      m_q.delete();
      m_pc = (fl ? fpc : bpc) & 32'hFFFF_FFFC;
    end else begin
      req    = !m_pending && (m_q.size() < DEPTH);
      do_pop = (m_q.size() != 0) && rdy;
      if (do_pop) void'(m_q.pop_front());
      if (rv && m_pending) begin
        m_pending = 0;
        if (m_drop) m_drop = 0;
        else m_q.push_back({m_pend_pc, rd});
      end else if (req && gnt) begin
        m_pending = 1;
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  // Zero-wait memory: always grants, answers addr|1 the cycle after a grant.
  task automatic run_mem(input int n, input bit rdy);
    repeat (n) applyStimulus(0, 0, 0, 0, 1, m_pending, m_pend_pc | 32'h1, rdy);
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    seen_pc.delete();
    seen_inst.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_sig = 0; branch_sig = 0; mem_gnt = 0; mem_rvalid = 0; decode_ready = 0;
    #1;
    check("rst_mem_req",    32'(mem_req),    32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst",       inst,            NOP);
    check("rst_pc",         pc,              32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RESET_PC; m_pend_pc = '0; m_pending = 0; m_drop = 0;
    m_q.delete();
    clear_logs();
  endtask

  initial begin
    @(negedge clk);

    // In-order stream from reset
    do_reset();
    run_mem(8, 1);
    check("t1_addr0", gnt_log[0], 32'h0);
    check("t1_addr1", gnt_log[1], 32'h4);
    check("t1_addr2", gnt_log[2], 32'h8);
    check("t1_inst0", seen_inst[0], 32'h1);  check("t1_pc0", seen_pc[0], 32'h0);
    check("t1_inst1", seen_inst[1], 32'h5);  check("t1_pc1", seen_pc[1], 32'h4);
    check("t1_inst2", seen_inst[2], 32'h9);  check("t1_pc2", seen_pc[2], 32'h8);

    // Decode stall fills the queue, then drains
    do_reset();
    run_mem(10, 0);
    check("t2_grants", 32'(gnt_log.size()), 32'd2);
    check("t2_req",    32'(mem_req), 32'h0);
    check("t2_inst",   inst, 32'h1);
    check("t2_pc",     pc,   32'h0);
    run_mem(4, 1);
    check("t2_drain0", seen_pc[0], 32'h0);
    check("t2_drain1", seen_pc[1], 32'h4);
    check("t2_resume", gnt_log[2], 32'h8);

    // Branch while a response is outstanding
    do_reset();
    run_mem(3, 1);
    clear_logs();
    applyStimulus(0, 0, 1, 32'h100, 1, 0, 0, 1);
    run_mem(5, 1);
    check("t3_addr", gnt_log[0], 32'h100);
    check("t3_pc",   seen_pc[0], 32'h100);
    check("t3_inst", seen_inst[0], 32'h101);

    // Flush and branch together with a response in the same cycle
    do_reset();
    run_mem(1, 1);
    applyStimulus(1, 32'h200, 1, 32'h100, 1, 1, 32'hBAD0_BAD0, 1);
    clear_logs();
    run_mem(4, 1);
    check("t4_addr", gnt_log[0], 32'h200);
    check("t4_pc",   seen_pc[0], 32'h200);
    check("t4_inst", seen_inst[0], 32'h201);

    // Unaligned target and PC wrap
    do_reset();
    applyStimulus(0, 0, 1, 32'h103, 0, 0, 0, 1);
    run_mem(2, 1);
    check("t5_align", gnt_log[0], 32'h100);
    applyStimulus(1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 1);
    clear_logs();
    run_mem(6, 1);
    check("t5_wrap0", gnt_log[0], 32'hFFFF_FFF8);
    check("t5_wrap1", gnt_log[1], 32'hFFFF_FFFC);
    check("t5_wrap2", gnt_log[2], 32'h0000_0000);

    // Reset mid-transaction, then a stray response
    do_reset();
    run_mem(3, 0);
    check("t6_pre_valid", 32'(inst_valid), 32'h1);
    do_reset();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    check("t6_queue_empty", 32'(inst_valid), 32'h0);
    run_mem(4, 1);
    check("t6_first_addr", gnt_log[0], RESET_PC);
    check("t6_first_inst", seen_inst[0], RESET_PC | 32'h1);

    // Random traffic against the model
    do_reset();
    repeat (600) begin
      applyStimulus($urandom_range(0, 99) < 3, $urandom,
                    $urandom_range(0, 99) < 5, $urandom,
                    $urandom_range(0, 99) < 70,
                    m_pending ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 10),
                    $urandom, $urandom_range(0, 99) < 65);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
Parametrised instruction-fetch stage with a decoupled prefetch queue.
- Owns the PC, issues word requests to instruction memory over a req/gnt + rvalid handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Decode pops the FIFO through a valid/ready handshake.
- Flush and branch redirects clear the queue and squash the in-flight response.
- Sits between the PC-redirect sources (flush interface, branch predictor) and decode.

Parameters:
- DEPTH, 2: FIFO entries. Must be ≥1; any integer is legal, not only powers of two.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- NOP, 32'h0000_0013: value driven on o_inst when the queue is empty (addi x0,x0,0).

Ports:
- i_clk  in  1  CPU clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush_sig  in  1  flush redirect request.
- i_flush_pc  in  32  flush target.
- i_branch_sig  in  1  branch-taken redirect request.
- i_branch_pc  in  32  branch target.
- o_mem_req  out  1  instruction memory request valid.
- o_mem_addr  out  32  request address, word aligned.
- i_mem_gnt  in  1  memory accepts the request this cycle.
- i_mem_rvalid  in  1  response valid.
- i_mem_rdata  in  32  response instruction.
- o_inst_valid  out  1  FIFO head valid.
- o_inst  out  32  head instruction, or NOP when empty.
- o_pc  out  32  PC of the head instruction, 0 when empty.
- i_decode_ready  in  1  decode accepts the head. Low = decode stall.

Behaviour:
- Reset (async, i_rst_n=0):
  - Registers: pc_q=RESET_PC, pending=0, drop=0, count=0, FIFO pointers=0.
  - Outputs: o_mem_req=0, o_inst_valid=0, o_inst=NOP, o_pc=0.
  - Reset asserted mid-transaction abandons everything. A response arriving after reset release with pending=0 is ignored.
- Redirect:
  - redirect = i_flush_sig | i_branch_sig. Flush has priority: if both are high, target = i_flush_pc.
  - Target bits [1:0] are forced to 0.
  - On the redirect cycle edge:
    - pc_q := target, count := 0, pointers := 0.
    - If pending=1 and no response arrives this cycle, drop := 1.
    - o_mem_req is 0 during the redirect cycle.
    - A pop in the same cycle is ignored.
    - A response in the same cycle is discarded and pending := 0.
- Request:
  - o_mem_req = !redirect & !pending & (count < DEPTH). Credit rule: one outstanding request maximum, and only when the FIFO has a guaranteed free slot.
  - o_mem_addr = pc_q.
  - On o_mem_req & i_mem_gnt: pending := 1, req_pc := pc_q, pc_q := pc_q + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - o_mem_req holds with a stable address until granted.
- Response:
  - On i_mem_rvalid & pending: pending := 0.
  - If drop=1, discard the data and set drop := 0.
  - Otherwise push {req_pc, i_mem_rdata}.
  - i_mem_rvalid with pending=0 is ignored.
  - Earliest response is the cycle after the grant.
- FIFO:
  - Circular buffer. Pointers wrap at DEPTH-1 → 0.
  - Pop on o_inst_valid & i_decode_ready & !redirect.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by the credit rule. A pop on empty is a no-op.
  - o_inst_valid = (count != 0).
  - Head outputs are combinational from head storage, with NOP/0 when empty.
- Latency:
  - Back-to-back flow with a zero-wait memory: one instruction every 2 cycles (req, then rvalid).
  - Redirect at edge T: new request at cycle T+1, response at T+2 at the earliest, o_inst_valid from T+3.
- Stall: i_decode_ready=0 holds the head stable. Fetching continues until count + pending == DEPTH, then o_mem_req drops.

Test Plan:
1. Reset release, memory grants immediately and returns rdata=addr|1 one cycle later, decode always ready → requests to 0x0, 0x4, 0x8. o_inst/o_pc pairs (0x1,0x0), (0x5,0x4), (0x9,0x8), in order.
2. DEPTH=2, i_decode_ready=0 for 10 cycles → exactly 2 grants, then o_mem_req=0. o_inst holds 0x1 and o_pc holds 0x0. After ready rises, both entries drain and fetch resumes at 0x8.
3. Request to 0x4 granted, then i_branch_sig=1 with i_branch_pc=0x100 before rvalid → response for 0x4 discarded. Next o_mem_addr=0x100. First valid o_pc=0x100.
4. i_flush_sig=1 (0x200) and i_branch_sig=1 (0x100) in the same cycle, with an rvalid in that cycle → response dropped, FIFO empty, next request at 0x200, pending=0, drop=0.
5. Redirect to 0x103 → o_mem_addr=0x100. Run from 0xFFFF_FFF8 → requests at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Assert i_rst_n=0 asynchronously mid-pending with count=1 → o_inst_valid and o_mem_req fall immediately, o_inst=NOP. After release, a stray rvalid is ignored and the first request is to RESET_PC.
